// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan front end.
// Holds the double-dabble nibble adjust and the signed-to-magnitude helper.
package seg_pkg;

    localparam int VAL_W      = 10;
    localparam int BCD_DIGITS = 3;
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int ITER_CNT   = 10;
    localparam int ITER_W     = $clog2(ITER_CNT);

    localparam logic [1:0] SIGN_SLOT = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    // Add 3 to every nibble that is 5 or more, ahead of the next left shift.
    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        res = bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

    // Two's-complement magnitude read back as unsigned, so -512 maps to 512.
    function automatic logic [VAL_W-1:0] magnitude(input logic [VAL_W-1:0] v);
        return v[VAL_W-1] ? (~v + VAL_W'(1)) : v;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 converter: one bit per cycle, start/done handshake.
// done pulses on the final iteration edge, with bcd_out carrying the result.
module bin2bcd_seq
    import seg_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [VAL_W-1:0] bin_in,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd_out
);

    state_t              state_q, state_d;
    logic [VAL_W-1:0]    shift_q, shift_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic [ITER_W-1:0]   iter_q, iter_d;
    logic [BCD_W-1:0]    adjusted;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path infers a latch.
        state_d  = state_q;
        shift_d  = shift_q;
        bcd_d    = bcd_q;
        iter_d   = iter_q;
        done     = 1'b0;
        adjusted = dabble_adjust(bcd_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d = bin_in;
                    bcd_d   = '0;
                    iter_d  = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                {bcd_d, shift_d} = {adjusted, shift_q} << 1;
                iter_d           = iter_q + 1'b1;
                if (iter_q == ITER_W'(ITER_CNT - 1)) begin
                    state_d = IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            bcd_q   <= '0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            iter_q  <= iter_d;
        end
    end

    assign busy    = (state_q == CONV);
    assign bcd_out = bcd_d;

endmodule

// File: rtl/seg_scan_driver.sv
// Captures a signed result, converts it to BCD and drives the digit scan.
// Display registers update only when a conversion completes.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [VAL_W-1:0] value,
    input  logic             load,
    input  logic             disp_en,
    output logic             busy,
    output logic             en,
    output logic [1:0]       count,
    output logic [3:0]       num,
    output logic             sign
);

    localparam int PS_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic             start;
    logic             done;
    logic [BCD_W-1:0] bcd_out;

    logic             sign_pend_q, sign_pend_d;
    logic [BCD_W-1:0] digits_q, digits_d;
    logic             sign_q, sign_d;
    logic [PS_W-1:0]  prescale_q, prescale_d;
    logic [1:0]       count_q, count_d;
    logic [3:0]       num_q, num_d;
    logic             en_q;

    // A load during a conversion never reaches the engine.
    assign start = load & ~busy;

    bin2bcd_seq u_bin2bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bin_in  (magnitude(value)),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out)
    );

    always_comb begin
        sign_pend_d = start ? value[VAL_W-1] : sign_pend_q;
        digits_d    = done ? bcd_out : digits_q;
        sign_d      = done ? sign_pend_q : sign_q;

        prescale_d = prescale_q + 1'b1;
        count_d    = count_q;
        if (prescale_q == PS_W'(REFRESH_DIV - 1)) begin
            prescale_d = '0;
            count_d    = count_q + 2'd1;
        end

        // Mux from next-state values so a slot change and a display update on one edge agree.
        case (count_d)
            2'd0:    num_d = digits_d[3:0];
            2'd1:    num_d = digits_d[7:4];
            2'd2:    num_d = digits_d[11:8];
            default: num_d = 4'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_pend_q <= 1'b0;
            digits_q    <= '0;
            sign_q      <= 1'b0;
            prescale_q  <= '0;
            count_q     <= '0;
            num_q       <= '0;
            en_q        <= 1'b0;
        end else begin
            sign_pend_q <= sign_pend_d;
            digits_q    <= digits_d;
            sign_q      <= sign_d;
            prescale_q  <= prescale_d;
            count_q     <= count_d;
            num_q       <= num_d;
            en_q        <= disp_en;
        end
    end

    assign en    = en_q;
    assign count = count_q;
    assign num   = num_q;
    assign sign  = sign_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with a 4-cycle refresh slot.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_seg_scan_driver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] value;
    logic       load;
    logic       disp_en;
    logic       busy;
    logic       en;
    logic [1:0] count;
    logic [3:0] num;
    logic       sign;

    int vectors    = 0;
    int miscompares = 0;

    seg_scan_driver #(.REFRESH_DIV(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .value   (value),
        .load    (load),
        .disp_en (disp_en),
        .busy    (busy),
        .en      (en),
        .count   (count),
        .num     (num),
        .sign    (sign)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Load at the next edge and track busy through E0..E10.
    task automatic do_load(input logic [9:0] v);
        @(negedge clk);
        value = v;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL load_busy_e0 v=%0d: busy=%b expected 1", $signed(v), busy);
        end
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            vectors++;
            if (busy !== (i < 10)) begin
                miscompares++;
                $display("FAIL load_busy_e%0d v=%0d: busy=%b expected %b", i, $signed(v), busy, (i < 10));
            end
        end
    endtask

    // Walk the scan through slots 0..3 and compare num on each, plus sign.
    task automatic test_digits(input logic [3:0] o, input logic [3:0] t,
                               input logic [3:0] h, input logic s);
        logic [3:0] exp_d [4];
        exp_d[0] = o;
        exp_d[1] = t;
        exp_d[2] = h;
        exp_d[3] = 4'd0;
        vectors++;
        if (sign !== s) begin
            miscompares++;
            $display("FAIL digits_sign: sign=%b expected %b", sign, s);
        end
        for (int slot = 0; slot < 4; slot++) begin
            int waited = 0;
            while (count !== 2'(slot) && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            vectors++;
            if (count !== 2'(slot)) begin
                miscompares++;
                $display("FAIL digits_slot_wait: count=%0d never reached %0d", count, slot);
            end else if (num !== exp_d[slot]) begin
                miscompares++;
                $display("FAIL digits_slot%0d: num=%0d expected %0d", slot, num, exp_d[slot]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        value   = '0;
        load    = 1'b0;
        disp_en = 1'b0;
        #3;
        vectors++;
        if ({busy, en, count, num, sign} !== 9'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: busy=%b en=%b count=%0d num=%0d sign=%b expected all 0",
                     busy, en, count, num, sign);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        disp_en = 1'b1;
        vectors++;
        if (en !== 1'b0) begin
            miscompares++;
            $display("FAIL en_latency_before: en=%b expected 0", en);
        end
        @(negedge clk);
        vectors++;
        if (en !== 1'b1) begin
            miscompares++;
            $display("FAIL en_latency_after: en=%b expected 1", en);
        end
    endtask

    task automatic test_positive();
        do_load(10'd251);
        test_digits(4'd1, 4'd5, 4'd2, 1'b0);
    endtask

    // 123 loaded, 456 offered three cycles later; 251 must stay visible until E10.
    task automatic test_overlap();
        logic [3:0] old_d [4];
        old_d[0] = 4'd1;
        old_d[1] = 4'd5;
        old_d[2] = 4'd2;
        old_d[3] = 4'd0;
        @(negedge clk);
        value = 10'd123;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            vectors++;
            if (busy !== (i < 10)) begin
                miscompares++;
                $display("FAIL overlap_busy_e%0d: busy=%b expected %b", i, busy, (i < 10));
            end
            if (i < 10) begin
                vectors++;
                if (num !== old_d[count] || sign !== 1'b0) begin
                    miscompares++;
                    $display("FAIL overlap_hold_e%0d: slot=%0d num=%0d sign=%b expected %0d/0",
                             i, count, num, sign, old_d[count]);
                end
            end
            if (i == 2) begin
                value = 10'd456;
                load  = 1'b1;
            end
            if (i == 3) load = 1'b0;
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL overlap_no_restart: busy=%b expected 0", busy);
        end
        test_digits(4'd3, 4'd2, 4'd1, 1'b0);
    endtask

    task automatic test_negative();
        do_load(10'h200);
        test_digits(4'd2, 4'd1, 4'd5, 1'b1);
        do_load(10'h3FF);
        test_digits(4'd1, 4'd0, 4'd0, 1'b1);
    endtask

    // Reset after five iterations of a 300 conversion; display showed -1 beforehand.
    task automatic test_reset_mid_conv();
        @(negedge clk);
        value = 10'd300;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (5) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, en, count, num, sign} !== 9'd0) begin
            miscompares++;
            $display("FAIL midconv_reset: busy=%b en=%b count=%0d num=%0d sign=%b expected all 0",
                     busy, en, count, num, sign);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midconv_idle: busy=%b expected 0", busy);
        end
        test_digits(4'd0, 4'd0, 4'd0, 1'b0);
        do_load(10'd99);
        test_digits(4'd9, 4'd9, 4'd0, 1'b0);
    endtask

    task automatic test_zero();
        do_load(10'h3FF);
        test_digits(4'd1, 4'd0, 4'd0, 1'b1);
        do_load(10'd0);
        test_digits(4'd0, 4'd0, 4'd0, 1'b0);
    endtask

    // count must hold each slot for exactly four cycles and wrap 3 -> 0.
    task automatic test_scan();
        logic [1:0] c;
        int         waited;
        @(negedge clk);
        c      = count;
        waited = 0;
        while (count === c && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        vectors++;
        if (count === c) begin
            miscompares++;
            $display("FAIL scan_start: count stuck at %0d", count);
        end
        for (int n = 0; n < 5; n++) begin
            c = count;
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                vectors++;
                if (count !== ((k < 4) ? c : c + 2'd1)) begin
                    miscompares++;
                    $display("FAIL scan_step%0d_k%0d: count=%0d expected %0d",
                             n, k, count, (k < 4) ? c : c + 2'd1);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_positive();
        test_overlap();
        test_negative();
        test_reset_mid_conv();
        test_zero();
        test_scan();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
